gerador_eco: RTL and testbench
==============================

Name: gerador_eco

Overview:
- Behavioural model of the ultrasonic sensor, synthesizable on the FPGA: the transmitting end of the echo interface that the cm-counter receiver measures.
- On a valid trigger pulse, waits a fixed delay, then drives `echo` high for exactly `distancia`×`CLK_PER_CM` clock cycles.
- Used for closed-loop board tests and as a bench stimulus for the distance-measurement path.

Parameters:
- CLK_PER_CM, 2941: clock cycles of echo per cm (58.82 us at 50 MHz).
- TRIG_MIN, 500: minimum trigger high width in cycles (10 us at 50 MHz).
- ATRASO, 25000: cycles between trigger acceptance and echo rise.
- DIST_W, 9: width of the `distancia` input.
- DIST_MAX, 400: largest valid distance in cm.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- trigger  in  1  measurement request from the trigger generator; synchronous to clock.
- distancia  in  DIST_W  simulated distance in cm, unsigned binary.
- echo  out  1  echo pulse to the receiver.
- ocupado  out  1  high in states atraso, eco and fim.
- pronto  out  1  one-cycle pulse in state fim.
- erro  out  1  last accepted measurement had an invalid distance.

Behaviour:
- Reset (reset=0, async): state=ocioso, all counters=0, trig_d=0, echo=0, ocupado=0, pronto=0, erro=0.
- trig_d is the trigger value registered on the previous clock.
- Outputs are Moore, decoded from registered state and erro register: echo=(state==eco), pronto=(state==fim).
- ocioso:
  - Moves to mede_trigger when trigger=1 and trig_d=0, i.e. on a rising edge; cnt_trig is set to 1.
  - A trigger already high when entering ocioso does not start a measurement until it is seen low first.
- mede_trigger:
  - While trigger=1, cnt_trig increments and saturates at TRIG_MIN.
  - When trigger=0 and cnt_trig>=TRIG_MIN: go to atraso, latch distancia into dist_r, clear erro.
  - When trigger=0 and cnt_trig<TRIG_MIN: return to ocioso. No pronto, erro unchanged.
  - Net effect: a trigger high for exactly TRIG_MIN sampled cycles is accepted; TRIG_MIN-1 is rejected.
- atraso:
  - Stays exactly ATRASO cycles; trigger is ignored.
  - If dist_r==0 or dist_r>DIST_MAX, go to fim and set erro=1. No echo is produced.
  - Otherwise go to eco with cnt_tick=0 and cnt_cm=0.
- eco:
  - cnt_tick counts 0..CLK_PER_CM-1 and wraps; cnt_cm increments on each wrap.
  - Leave to fim on the cycle where cnt_cm==dist_r-1 and cnt_tick==CLK_PER_CM-1.
  - echo is therefore high for exactly dist_r×CLK_PER_CM consecutive cycles.
- fim: lasts 1 cycle (pronto=1), then goes to ocioso.
- distancia changes after latching have no effect on the current pulse.
- Trigger activity in atraso, eco or fim is ignored. A new measurement needs a rising edge seen in ocioso.
- Counter widths: use $clog2 of each limit, sized so no counter overflows. cnt_cm is DIST_W bits.
- erro holds its value until the next accepted trigger, which clears it.
- Reset asserted mid-operation: echo drops immediately (async), the pulse is aborted, and no pronto is issued.
- Unused state encodings go to ocioso.

Test Plan:
(bench parameters: CLK_PER_CM=4, TRIG_MIN=5, ATRASO=3, DIST_MAX=400)
- trigger high 5 cycles, distancia=3 -> echo rises 3 cycles after trigger is sampled low; echo high exactly 12 cycles; one pronto pulse; erro=0; ocupado high from atraso through fim.
- trigger high 4 cycles, distancia=3 -> echo never rises, no pronto, ocupado stays 0, state returns to ocioso.
- distancia=0, then distancia=401, each with a valid trigger -> no echo; pronto pulse with erro=1 each time. A following valid run with distancia=1 -> echo high 4 cycles and erro cleared to 0.
- distancia=2 latched, then changed to 7 during eco, plus extra trigger pulses during atraso and eco -> echo width stays 8 cycles and exactly one pronto pulse.
- trigger held high across the whole measurement -> exactly one echo; a second echo only after trigger goes 0 and then high again for at least 5 cycles.
- reset pulled low in the middle of eco -> echo=0 in the same cycle, no pronto; after release, a valid trigger with distancia=400 -> echo high exactly 1600 cycles.

Source files
------------

// File: rtl/gerador_eco_if.sv
// Echo-interface bundle between a trigger source (master) and the echo generator (slave).
interface gerador_eco_if #(
  parameter int unsigned DIST_W = 9
);
  logic              trigger;
  logic [DIST_W-1:0] distancia;
  logic              echo;
  logic              ocupado;
  logic              pronto;
  logic              erro;

  modport master (
    output trigger,
    output distancia,
    input  echo,
    input  ocupado,
    input  pronto,
    input  erro
  );

  modport slave (
    input  trigger,
    input  distancia,
    output echo,
    output ocupado,
    output pronto,
    output erro
  );
endinterface

// File: rtl/gerador_eco.sv
// Ultrasonic sensor model: after a valid trigger and a fixed delay, drives echo high for
// distancia * CLK_PER_CM cycles; invalid distances produce no echo and flag erro.
module gerador_eco #(
  parameter int unsigned CLK_PER_CM = 2941,
  parameter int unsigned TRIG_MIN   = 500,
  parameter int unsigned ATRASO     = 25000,
  parameter int unsigned DIST_W     = 9,
  parameter int unsigned DIST_MAX   = 400
) (
  input  logic            clock,
  input  logic            reset,
  gerador_eco_if.slave    intf
);

  localparam int unsigned TrigW = $clog2(TRIG_MIN + 1);
  localparam int unsigned AtrW  = $clog2(ATRASO + 1);
  localparam int unsigned TickW = $clog2(CLK_PER_CM + 1);

  localparam logic [TrigW-1:0]  TrigMin  = TrigW'(TRIG_MIN);
  localparam logic [AtrW-1:0]   AtrLast  = AtrW'(ATRASO - 1);
  localparam logic [TickW-1:0]  TickLast = TickW'(CLK_PER_CM - 1);
  localparam logic [DIST_W-1:0] DistMax  = DIST_W'(DIST_MAX);

  typedef enum logic [2:0] {
    StOcioso      = 3'd0,
    StMedeTrigger = 3'd1,
    StAtraso      = 3'd2,
    StEco         = 3'd3,
    StFim         = 3'd4
  } state_e;

  state_e            state_q;
  logic              trig_q;
  logic              erro_q;
  logic [TrigW-1:0]  cnt_trig_q;
  logic [AtrW-1:0]   cnt_atraso_q;
  logic [TickW-1:0]  cnt_tick_q;
  logic [DIST_W-1:0] cnt_cm_q;
  logic [DIST_W-1:0] dist_q;
  logic              dist_invalid;

  assign dist_invalid = (dist_q == '0) || (dist_q > DistMax);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StOcioso;
      trig_q       <= 1'b0;
      erro_q       <= 1'b0;
      cnt_trig_q   <= '0;
      cnt_atraso_q <= '0;
      cnt_tick_q   <= '0;
      cnt_cm_q     <= '0;
      dist_q       <= '0;
    end else begin
      trig_q <= intf.trigger;
      unique case (state_q)
        StOcioso: begin
          // Rising edge only: a trigger still high from a previous run must drop first.
          if (intf.trigger && !trig_q) begin
            state_q    <= StMedeTrigger;
            cnt_trig_q <= TrigW'(1);
          end
        end
        StMedeTrigger: begin
          if (intf.trigger) begin
            if (cnt_trig_q < TrigMin) cnt_trig_q <= cnt_trig_q + 1'b1;
          end else if (cnt_trig_q >= TrigMin) begin
            state_q      <= StAtraso;
            dist_q       <= intf.distancia;
            erro_q       <= 1'b0;
            cnt_atraso_q <= '0;
          end else begin
            state_q <= StOcioso;
          end
        end
        StAtraso: begin
          if (cnt_atraso_q == AtrLast) begin
            if (dist_invalid) begin
              state_q <= StFim;
              erro_q  <= 1'b1;
            end else begin
              state_q    <= StEco;
              cnt_tick_q <= '0;
              cnt_cm_q   <= '0;
            end
          end else begin
            cnt_atraso_q <= cnt_atraso_q + 1'b1;
          end
        end
        StEco: begin
          if (cnt_tick_q == TickLast) begin
            cnt_tick_q <= '0;
            if (cnt_cm_q == dist_q - DIST_W'(1)) state_q <= StFim;
            else cnt_cm_q <= cnt_cm_q + 1'b1;
          end else begin
            cnt_tick_q <= cnt_tick_q + 1'b1;
          end
        end
        StFim:   state_q <= StOcioso;
        default: state_q <= StOcioso;
      endcase
    end
  end

  assign intf.echo    = (state_q == StEco);
  assign intf.pronto  = (state_q == StFim);
  assign intf.ocupado = (state_q == StAtraso) || (state_q == StEco) || (state_q == StFim);
  assign intf.erro    = erro_q;

endmodule

// File: tb/tb_gerador_eco.sv
// Randomized bench for gerador_eco checked every cycle against a timeline model of the
// measurement (busy window, echo window, erro onset) computed from the trigger history.
module tb_gerador_eco;

  localparam int CPC  = 4;
  localparam int TMIN = 5;
  localparam int ATR  = 3;
  localparam int DW   = 9;
  localparam int DMAX = 400;
  localparam int INF  = 1 << 30;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  gerador_eco_if #(.DIST_W(DW)) intf ();

  gerador_eco #(
    .CLK_PER_CM(CPC),
    .TRIG_MIN  (TMIN),
    .ATRASO    (ATR),
    .DIST_W    (DW),
    .DIST_MAX  (DMAX)
  ) dut (
    .clock(clock),
    .reset(reset),
    .intf (intf)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference timeline: cycle n is the interval after the n-th rising edge.
  int cyc = 0;
  int bs, be, es, ee, err_cyc;
  bit meas, p;
  int run;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    bs = 0; be = -1; es = INF; ee = -1; err_cyc = INF;
    meas = 0; p = 0; run = 0;
  endtask

  task automatic model_accept(input int n, input int d);
    bs = n;
    if (d == 0 || d > DMAX) begin
      es = INF; ee = -1;
      be = n + ATR;
      err_cyc = n + ATR;
    end else begin
      es = n + ATR;
      ee = es + d * CPC - 1;
      be = ee + 1;
      err_cyc = INF;
    end
  endtask

  task automatic model_edge(input bit t, input int d);
    bit prev_busy;
    prev_busy = (cyc - 1 >= bs) && (cyc - 1 <= be);
    if (!prev_busy) begin
      if (meas) begin
        if (t) run++;
        else begin
          meas = 0;
          if (run >= TMIN) model_accept(cyc, d);
        end
      end else if (t && !p) begin
        meas = 1;
        run  = 1;
      end
    end
    p = t;
  endtask

  task automatic check_outputs(input string sfx);
    check_eq({"echo", sfx},    intf.echo,    32'((cyc >= es) && (cyc <= ee)));
    check_eq({"pronto", sfx},  intf.pronto,  32'(cyc == be));
    check_eq({"ocupado", sfx}, intf.ocupado, 32'((cyc >= bs) && (cyc <= be)));
    check_eq({"erro", sfx},    intf.erro,    32'(cyc >= err_cyc));
  endtask

  task automatic step(input bit t, input int d);
    intf.trigger   = t;
    intf.distancia = DW'(d);
    @(posedge clock);
    cyc++;
    if (!reset) model_reset();
    else model_edge(t, d);
    #1;
    check_outputs("");
  endtask

  task automatic idle(input int n, input int d);
    for (int i = 0; i < n; i++) step(1'b0, d);
  endtask

  task automatic pulse(input int len, input int d);
    for (int i = 0; i < len; i++) step(1'b1, d);
    step(1'b0, d);
  endtask

  initial begin
    int len, d, r, gap;
    model_reset();
    intf.trigger   = 1'b0;
    intf.distancia = '0;

    // Reset state
    idle(3, 0);
    reset = 1'b1;
    idle(2, 3);

    // Valid 5-cycle trigger, 3 cm
    pulse(5, 3);
    idle(25, 3);

    // Too-short trigger
    pulse(4, 3);
    idle(10, 3);

    // Invalid distances, then recovery with 1 cm
    pulse(5, 0);
    idle(10, 0);
    pulse(5, 401);
    idle(10, 401);
    pulse(5, 1);
    idle(15, 1);

    // Latched distance survives changes; extra triggers ignored while busy
    pulse(5, 2);
    for (int i = 0; i < 20; i++) step(1'(i % 3 == 0), 7);
    idle(10, 7);

    // Trigger held high through the measurement and beyond
    pulse(5, 2);
    for (int i = 0; i < 40; i++) step(1'b1, 2);
    step(1'b0, 2);
    pulse(5, 2);
    idle(25, 2);

    // Reset mid-eco: echo must drop before the next edge
    pulse(5, 10);
    idle(ATR + 5, 10);
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs("_async");
    idle(2, 10);
    reset = 1'b1;
    idle(3, 400);
    pulse(5, 400);
    idle(1610, 400);

    // Randomized runs
    for (int k = 0; k < 40; k++) begin
      len = $urandom_range(3, 7);
      r   = $urandom_range(0, 9);
      if (r == 0) d = 0;
      else if (r == 1) d = $urandom_range(401, 511);
      else d = $urandom_range(1, 6);
      pulse(len, d);
      gap = $urandom_range(0, 40);
      for (int i = 0; i < gap; i++) step(1'(($urandom % 4) == 0), $urandom_range(0, 511));
      idle(ATR + 6 * CPC + 4, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
